pc_sequencer: RTL and testbench

Program-counter and fetch-sequencing stage that sits directly upstream of `instruction_fetch`. It owns the architectural PC, drives `instruction_adr_i` and the fetch request into the fetch stage, and captures the returned instruction word for decode. It applies execute-stage redirects (branch/jump) and decode back-pressure. It flags misaligned targets and stops fetching on halt or fault.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/pc_next_logic.sv | 28 ++
 rtl/pc_sequencer.sv | 151 +++++++++++++++
 tb/tb_pc_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the PC/fetch sequencer
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_HALTED = 3'd4,
    ST_FAULT  = 3'd5
  } pc_state_t;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_KEEP,
    SEL_INCR,
    SEL_TARGET,
    SEL_PENDING
  } pc_sel_t;

  localparam logic [31:0] PC_INCR              = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;

endpackage

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - next-PC selection and redirect alignment check
module pc_next_logic
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  pc_sel_t     sel,
  input  logic [31:0] pc,
  input  logic [31:0] target,
  input  logic [31:0] pending_target,
  output logic [31:0] next_pc,
  output logic        target_misaligned
);

  assign target_misaligned = (target[1:0] != 2'b00);

  always_comb begin
    next_pc = pc;
    case (sel)
      SEL_RESET:   next_pc = RESET_VECTOR;
      SEL_INCR:    next_pc = pc + PC_INCR;
      SEL_TARGET:  next_pc = target;
      SEL_PENDING: next_pc = pending_target;
      default:     next_pc = pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and fetch sequencing stage
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_done_i,
  input  logic [31:0] instr_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  input  logic        halt_i,
  output logic [31:0] instruction_adr_o,
  output logic        fetch_req_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o,
  output logic        misaligned_o,
  output logic [2:0]  state_o
);

  pc_state_t   state, state_d;
  pc_sel_t     sel;
  logic [31:0] pc, next_pc, pending_target, pending_target_d;
  logic        redirect_pending, redirect_pending_d;
  logic        halt_pending, halt_pending_d;
  logic        capture, valid_d, set_misaligned, target_misaligned;
  logic        halt_any;

  pc_next_logic #(.RESET_VECTOR(RESET_VECTOR)) u_next (
    .sel               (sel),
    .pc                (pc),
    .target            (redirect_target_i),
    .pending_target    (pending_target),
    .next_pc           (next_pc),
    .target_misaligned (target_misaligned)
  );

  assign halt_any = halt_i | halt_pending;

  always_comb begin
    state_d            = state;
    sel                = SEL_KEEP;
    capture            = 1'b0;
    valid_d            = 1'b0;
    set_misaligned     = 1'b0;
    redirect_pending_d = redirect_pending;
    pending_target_d   = pending_target;
    halt_pending_d     = halt_pending;
    case (state)
      ST_RESET: begin
        sel     = SEL_RESET;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redirect_i && target_misaligned) begin
          set_misaligned = 1'b1;
          state_d        = ST_FAULT;
        end else if (redirect_i) begin
          sel     = SEL_TARGET;
          state_d = halt_i ? ST_HALTED : ST_REQ;
        end else begin
          state_d = halt_i ? ST_HALTED : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_i && target_misaligned) begin
          set_misaligned = 1'b1;
          state_d        = ST_FAULT;
        end else if (fetch_done_i) begin
          redirect_pending_d = 1'b0;
          halt_pending_d     = 1'b0;
          // A redirect seen at any point of this fetch discards the returned word.
          if (redirect_i) begin
            sel = SEL_TARGET;
          end else if (redirect_pending) begin
            sel = SEL_PENDING;
          end else begin
            capture = 1'b1;
            valid_d = 1'b1;
            if (!halt_any && !stall_i) sel = SEL_INCR;
          end
          if (halt_any)                 state_d = ST_HALTED;
          else if (capture && stall_i)  state_d = ST_HOLD;
          else                          state_d = ST_REQ;
        end else begin
          if (redirect_i) begin
            redirect_pending_d = 1'b1;
            pending_target_d   = redirect_target_i;
          end
          halt_pending_d = halt_any;
        end
      end
      ST_HOLD: begin
        valid_d = 1'b1;
        if (redirect_i && target_misaligned) begin
          valid_d        = 1'b0;
          set_misaligned = 1'b1;
          state_d        = ST_FAULT;
        end else if (redirect_i) begin
          valid_d = 1'b0;
          sel     = SEL_TARGET;
          state_d = halt_i ? ST_HALTED : ST_REQ;
        end else if (halt_i) begin
          valid_d = 1'b0;
          state_d = ST_HALTED;
        end else if (!stall_i) begin
          valid_d = 1'b0;
          sel     = SEL_INCR;
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = state;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_RESET;
      pc               <= RESET_VECTOR;
      pending_target   <= 32'd0;
      redirect_pending <= 1'b0;
      halt_pending     <= 1'b0;
      instr_o          <= 32'd0;
      pc_o             <= 32'd0;
      instr_valid_o    <= 1'b0;
      misaligned_o     <= 1'b0;
    end else begin
      state            <= state_d;
      pc               <= next_pc;
      pending_target   <= pending_target_d;
      redirect_pending <= redirect_pending_d;
      halt_pending     <= halt_pending_d;
      instr_valid_o    <= valid_d;
      if (set_misaligned) misaligned_o <= 1'b1;
      if (capture) begin
        instr_o <= instr_i;
        pc_o    <= pc;
      end
    end
  end

  assign instruction_adr_o = pc;
  assign fetch_req_o       = (state == ST_REQ) || (state == ST_WAIT);
  assign state_o           = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_done_i = 1'b0;
  logic [31:0] instr_i = 32'd0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_target_i = 32'd0;
  logic        halt_i = 1'b0;
  logic [31:0] instruction_adr_o, instr_o, pc_o;
  logic        fetch_req_o, instr_valid_o, misaligned_o;
  logic [2:0]  state_o;
  logic [31:0] adr2, instr2, pc2;
  logic        req2, valid2, mis2;
  logic [2:0]  state2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .fetch_done_i(fetch_done_i), .instr_i(instr_i),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
    .halt_i(halt_i), .instruction_adr_o(instruction_adr_o), .fetch_req_o(fetch_req_o),
    .instr_o(instr_o), .pc_o(pc_o), .instr_valid_o(instr_valid_o),
    .misaligned_o(misaligned_o), .state_o(state_o)
  );

  pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .fetch_done_i(fetch_done_i), .instr_i(instr_i),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
    .halt_i(halt_i), .instruction_adr_o(adr2), .fetch_req_o(req2),
    .instr_o(instr2), .pc_o(pc2), .instr_valid_o(valid2),
    .misaligned_o(mis2), .state_o(state2)
  );

  typedef struct {
    logic        done;
    logic [31:0] instr;
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_adr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vt [14];

  function automatic vec_t mk(input logic d, input logic [31:0] ins, input logic s,
                              input logic rq, input logic [31:0] a, input logic v,
                              input logic [31:0] p, input logic [31:0] ei);
    vec_t r;
    r.done = d; r.instr = ins; r.stall = s; r.exp_req = rq;
    r.exp_adr = a; r.exp_valid = v; r.exp_pc = p; r.exp_instr = ei;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural reference: phases named by what the stage is doing, not by RTL encoding.
  localparam int BOOT = 0, ISSUE = 1, AWAIT = 2, HOLDING = 3, STOPPED = 4, FAULTED = 5;
  bit          use_model = 0;
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_pco, m_ptgt;
  logic        m_valid, m_mis, m_pend, m_hpend;

  task automatic model_reset();
    m_phase = BOOT; m_pc = 32'd0; m_instr = 32'd0; m_pco = 32'd0; m_ptgt = 32'd0;
    m_valid = 0; m_mis = 0; m_pend = 0; m_hpend = 0;
  endtask

  task automatic model_step();
    logic bad;
    logic hp;
    bad = redirect_i && (redirect_target_i % 4 != 0);
    if (!rst) return;
    if (m_phase == BOOT) begin
      m_pc = 32'd0; m_phase = ISSUE; m_valid = 0;
    end else if (m_phase == ISSUE) begin
      m_valid = 0;
      if (bad) begin m_mis = 1; m_phase = FAULTED; end
      else if (redirect_i) begin m_pc = redirect_target_i; m_phase = halt_i ? STOPPED : ISSUE; end
      else m_phase = halt_i ? STOPPED : AWAIT;
    end else if (m_phase == AWAIT) begin
      m_valid = 0;
      hp = m_hpend || halt_i;
      if (bad) begin m_mis = 1; m_phase = FAULTED; end
      else if (fetch_done_i) begin
        if (redirect_i || m_pend) begin
          m_pc = redirect_i ? redirect_target_i : m_ptgt;
          m_phase = hp ? STOPPED : ISSUE;
        end else begin
          m_instr = instr_i; m_pco = m_pc; m_valid = 1;
          if (hp) m_phase = STOPPED;
          else if (stall_i) m_phase = HOLDING;
          else begin m_pc = m_pc + 4; m_phase = ISSUE; end
        end
        m_pend = 0; m_hpend = 0;
      end else begin
        if (redirect_i) begin m_pend = 1; m_ptgt = redirect_target_i; end
        m_hpend = hp;
      end
    end else if (m_phase == HOLDING) begin
      if (bad) begin m_valid = 0; m_mis = 1; m_phase = FAULTED; end
      else if (redirect_i) begin m_valid = 0; m_pc = redirect_target_i; m_phase = halt_i ? STOPPED : ISSUE; end
      else if (halt_i) begin m_valid = 0; m_phase = STOPPED; end
      else if (!stall_i) begin m_valid = 0; m_pc = m_pc + 4; m_phase = ISSUE; end
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic model_compare();
    chk("rnd_req", {31'd0, fetch_req_o}, {31'd0, (m_phase == ISSUE) || (m_phase == AWAIT)});
    chk("rnd_adr", instruction_adr_o, m_pc);
    chk("rnd_valid", {31'd0, instr_valid_o}, {31'd0, m_valid});
    chk("rnd_pc", pc_o, m_pco);
    chk("rnd_instr", instr_o, m_instr);
    chk("rnd_mis", {31'd0, misaligned_o}, {31'd0, m_mis});
  endtask

  task automatic tick();
    @(posedge clk);
    if (use_model) model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fetch_done_i = 0; stall_i = 0; redirect_i = 0; halt_i = 0;
  endtask

  initial begin
    vt[0]  = mk(0, 32'd0,          0, 1, 32'h0,  0, 32'h0, 32'd0);
    vt[1]  = mk(0, 32'd0,          0, 1, 32'h0,  0, 32'h0, 32'd0);
    vt[2]  = mk(1, NOP_INSTR,      0, 1, 32'h4,  1, 32'h0, NOP_INSTR);
    vt[3]  = mk(0, 32'd0,          0, 1, 32'h4,  0, 32'h0, NOP_INSTR);
    vt[4]  = mk(1, NOP_INSTR,      0, 1, 32'h8,  1, 32'h4, NOP_INSTR);
    vt[5]  = mk(0, 32'd0,          0, 1, 32'h8,  0, 32'h4, NOP_INSTR);
    vt[6]  = mk(1, 32'hAAAA_0013,  1, 0, 32'h8,  1, 32'h8, 32'hAAAA_0013);
    vt[7]  = mk(0, 32'd0,          1, 0, 32'h8,  1, 32'h8, 32'hAAAA_0013);
    vt[8]  = mk(0, 32'd0,          1, 0, 32'h8,  1, 32'h8, 32'hAAAA_0013);
    vt[9]  = mk(0, 32'd0,          1, 0, 32'h8,  1, 32'h8, 32'hAAAA_0013);
    vt[10] = mk(0, 32'd0,          0, 1, 32'hC,  0, 32'h8, 32'hAAAA_0013);
    vt[11] = mk(0, 32'd0,          0, 1, 32'hC,  0, 32'h8, 32'hAAAA_0013);
    vt[12] = mk(1, 32'h1234_5678,  0, 1, 32'h10, 1, 32'hC, 32'h1234_5678);
    vt[13] = mk(0, 32'd0,          0, 1, 32'h10, 0, 32'hC, 32'h1234_5678);

    @(negedge clk);
    chk("rst_state", {29'd0, state_o}, {29'd0, ST_RESET});
    chk("rst_adr", instruction_adr_o, 32'h0);
    chk("rst_req", {31'd0, fetch_req_o}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_mis", {31'd0, misaligned_o}, 32'd0);
    chk("rst_adr2", adr2, 32'hFFFF_FFFC);
    rst = 1;

    for (int i = 0; i < 14; i++) begin
      fetch_done_i = vt[i].done; instr_i = vt[i].instr; stall_i = vt[i].stall;
      tick();
      chk($sformatf("v%0d_req", i), {31'd0, fetch_req_o}, {31'd0, vt[i].exp_req});
      chk($sformatf("v%0d_adr", i), instruction_adr_o, vt[i].exp_adr);
      chk($sformatf("v%0d_valid", i), {31'd0, instr_valid_o}, {31'd0, vt[i].exp_valid});
      chk($sformatf("v%0d_pc", i), pc_o, vt[i].exp_pc);
      chk($sformatf("v%0d_instr", i), instr_o, vt[i].exp_instr);
      chk($sformatf("v%0d_adr2", i), adr2, vt[i].exp_adr - 32'd4);
    end
    idle_inputs();

    // Redirect during WAIT at 0x10, word returns two cycles later and is dropped.
    redirect_i = 1; redirect_target_i = 32'h100;
    tick();
    chk("rd_wait_state", {29'd0, state_o}, {29'd0, ST_WAIT});
    chk("rd_wait_adr", instruction_adr_o, 32'h10);
    redirect_i = 0;
    tick();
    fetch_done_i = 1; instr_i = 32'hBAD0_0013;
    tick();
    chk("rd_discard_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rd_new_adr", instruction_adr_o, 32'h100);
    chk("rd_new_req", {31'd0, fetch_req_o}, 32'd1);
    chk("rd_instr_kept", instr_o, 32'h1234_5678);

    // Redirect coinciding with fetch_done drops the word, then halt while waiting at 0x20.
    fetch_done_i = 0;
    tick();
    redirect_i = 1; redirect_target_i = 32'h20; fetch_done_i = 1;
    tick();
    chk("rd_same_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rd_same_adr", instruction_adr_o, 32'h20);
    idle_inputs();
    tick();
    halt_i = 1;
    tick();
    chk("halt_wait_req", {31'd0, fetch_req_o}, 32'd1);
    halt_i = 0; fetch_done_i = 1; instr_i = 32'hC0DE_0013;
    tick();
    chk("halt_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("halt_pc", pc_o, 32'h20);
    chk("halt_instr", instr_o, 32'hC0DE_0013);
    chk("halt_state", {29'd0, state_o}, {29'd0, ST_HALTED});
    fetch_done_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_no_req", {31'd0, fetch_req_o}, 32'd0);
      chk("halt_no_valid", {31'd0, instr_valid_o}, 32'd0);
    end

    // Misaligned redirect target faults until reset.
    rst = 0;
    #1;
    chk("rst2_state", {29'd0, state_o}, {29'd0, ST_RESET});
    @(negedge clk);
    rst = 1;
    tick();
    redirect_i = 1; redirect_target_i = 32'h102;
    tick();
    redirect_i = 0;
    chk("mis_flag", {31'd0, misaligned_o}, 32'd1);
    chk("mis_state", {29'd0, state_o}, {29'd0, ST_FAULT});
    for (int i = 0; i < 3; i++) begin
      fetch_done_i = 1;
      tick();
      chk("mis_no_req", {31'd0, fetch_req_o}, 32'd0);
    end
    fetch_done_i = 0;
    rst = 0;
    #1;
    chk("mis_clear", {31'd0, misaligned_o}, 32'd0);
    chk("mis_rst_state", {29'd0, state_o}, {29'd0, ST_RESET});

    // Randomized traffic against the reference model.
    model_reset();
    use_model = 1;
    @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      if (((m_phase == STOPPED || m_phase == FAULTED) && $urandom_range(0, 7) == 0) ||
          $urandom_range(0, 299) == 0) begin
        rst = 0;
        model_reset();
        #1;
        model_compare();
      end else begin
        rst = 1;
      end
      fetch_done_i = ($urandom_range(0, 1) == 1);
      instr_i = $urandom;
      stall_i = ($urandom_range(0, 3) == 0);
      redirect_i = ($urandom_range(0, 15) == 0);
      redirect_target_i = {$urandom_range(0, 32'h3FFF_FFFF) & 30'h3FFF_FFFF, 2'b00};
      if ($urandom_range(0, 9) == 0) redirect_target_i[1:0] = 2'($urandom_range(1, 3));
      halt_i = ($urandom_range(0, 63) == 0);
      tick();
      model_compare();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
